// File: rtl/i2c_target_rx_if.sv
// Synchronized I2C line signals plus the received-byte handshake of the write-only target.
interface i2c_target_rx_if;
    logic       sck_synced;
    logic       sda_synced;
    logic       start_condition;
    logic       stop_condition;
    logic       sda_drive_low;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_first;
    logic       byte_ready;
    logic       busy;
    logic       overrun;

    modport master (
        output sck_synced, sda_synced, start_condition, stop_condition, byte_ready,
        input  sda_drive_low, byte_data, byte_valid, byte_first, busy, overrun
    );

    modport slave (
        input  sck_synced, sda_synced, start_condition, stop_condition, byte_ready,
        output sda_drive_low, byte_data, byte_valid, byte_first, busy, overrun
    );
endinterface

// File: rtl/i2c_target_rx.sv
// I2C write-only target: matches the address, ACKs and hands each data byte to a one-deep holding register.
// A byte arriving while the holding register is still full is NACKed and flagged in the sticky overrun bit.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
    input logic            clk,
    input logic            reset,
    i2c_target_rx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic       sck_prev_q;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       first_out_q, first_out_d;
    logic       first_flag_q, first_flag_d;
    logic       overrun_q, overrun_d;

    logic       sck_rise;
    logic       sck_fall;
    logic [7:0] shifted;
    logic       hold_free;

    assign sck_rise  = bus.sck_synced & ~sck_prev_q;
    assign sck_fall  = ~bus.sck_synced & sck_prev_q;
    assign shifted   = {shift_q[6:0], bus.sda_synced};
    assign hold_free = ~valid_q | bus.byte_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sck_prev_q   <= 1'b0;
            shift_q      <= 8'h00;
            cnt_q        <= 3'd0;
            sda_low_q    <= 1'b0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            first_out_q  <= 1'b0;
            first_flag_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            sck_prev_q   <= bus.sck_synced;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            sda_low_q    <= sda_low_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            first_out_q  <= first_out_d;
            first_flag_q <= first_flag_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        sda_low_d    = sda_low_q;
        data_d       = data_q;
        valid_d      = valid_q;
        first_out_d  = first_out_q;
        first_flag_d = first_flag_q;
        overrun_d    = overrun_q;

        // Consumption first so that a same-cycle load below can override it.
        if (valid_q && bus.byte_ready) begin
            valid_d = 1'b0;
        end

        if (bus.start_condition) begin
            state_d   = ADDR;
            cnt_d     = 3'd0;
            sda_low_d = 1'b0;
        end else if (bus.stop_condition) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, IGNORE: begin
                    sda_low_d = 1'b0;
                end
                ADDR: begin
                    sda_low_d = 1'b0;
                    if (sck_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shifted[7:1] == TARGET_ADDR && !shifted[0]) begin
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (state_q == ADDR_ACK) begin
                        first_flag_d = 1'b1;
                    end
                    // First fall ends bit 8 and starts the ACK; the second fall ends the ACK clock.
                    if (sck_fall) begin
                        if (!sda_low_q) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = DATA;
                            cnt_d     = 3'd0;
                        end
                    end
                end
                DATA: begin
                    sda_low_d = 1'b0;
                    if (sck_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (hold_free) begin
                                data_d       = shifted;
                                valid_d      = 1'b1;
                                first_out_d  = first_flag_q;
                                first_flag_d = 1'b0;
                                state_d      = DATA_ACK;
                            end else begin
                                overrun_d = 1'b1;
                                state_d   = IGNORE;
                            end
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_drive_low = sda_low_q;
    assign bus.byte_data     = data_q;
    assign bus.byte_valid    = valid_q;
    assign bus.byte_first    = first_out_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: bit-level I2C write stimulus, received bytes checked through an expected-byte queue.
module tb_i2c_target_rx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i2c_target_rx_if bus();

    i2c_target_rx #(.TARGET_ADDR(7'h2A)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         drive_cnt = 0;
    int         snap;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.sck_synced = 1'b0;
        wait_clk(2);
        bus.sda_synced = b;
        wait_clk(2);
        bus.sck_synced = 1'b1;
        wait_clk(2);
    endtask

    // Eight data bits, then the ninth clock with SDA released; samples the target's ACK mid-high.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        bus.sck_synced = 1'b0;
        wait_clk(2);
        bus.sda_synced = 1'b1;
        wait_clk(2);
        bus.sck_synced = 1'b1;
        wait_clk(1);
        check(name, bus.sda_drive_low, exp_ack);
        wait_clk(1);
    endtask

    task automatic do_start();
        bus.sck_synced = 1'b0;
        wait_clk(2);
        bus.sda_synced = 1'b1;
        wait_clk(2);
        bus.sck_synced = 1'b1;
        wait_clk(2);
        bus.sda_synced = 1'b0;
        bus.start_condition = 1'b1;
        wait_clk(1);
        bus.start_condition = 1'b0;
        wait_clk(1);
    endtask

    task automatic do_stop();
        bus.sck_synced = 1'b0;
        wait_clk(2);
        bus.sda_synced = 1'b0;
        wait_clk(2);
        bus.sck_synced = 1'b1;
        wait_clk(2);
        bus.sda_synced = 1'b1;
        bus.stop_condition = 1'b1;
        wait_clk(1);
        bus.stop_condition = 1'b0;
        wait_clk(2);
    endtask

    initial begin
        reset = 1'b1;
        bus.sck_synced = 1'b1;
        bus.sda_synced = 1'b1;
        bus.start_condition = 1'b0;
        bus.stop_condition = 1'b0;
        bus.byte_ready = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (!reset) begin
                    if (bus.sda_drive_low) drive_cnt++;
                    if (bus.byte_valid && bus.byte_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_byte: got %0h expected none", bus.byte_data);
                        end else begin
                            mon_e = exp_q.pop_front();
                            if ({bus.byte_first, bus.byte_data} !== mon_e) begin
                                errors++;
                                $display("FAIL byte_out: got first=%0b data=%0h expected first=%0b data=%0h",
                                         bus.byte_first, bus.byte_data, mon_e[8], mon_e[7:0]);
                            end
                        end
                    end
                end
            end
        join_none

        wait_clk(4);
        check("rst_drive", bus.sda_drive_low, 0);
        check("rst_valid", bus.byte_valid, 0);
        check("rst_first", bus.byte_first, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_data", bus.byte_data, 0);
        reset = 1'b0;
        wait_clk(2);

        // Simple write of one byte with the consumer always ready
        do_start();
        check("start_busy", bus.busy, 1);
        send_byte(8'h54, 1'b1, "t1_addr_ack");
        exp_q.push_back({1'b1, 8'hA5});
        send_byte(8'hA5, 1'b1, "t1_data_ack");
        do_stop();
        check("t1_idle", bus.busy, 0);
        check("t1_release", bus.sda_drive_low, 0);

        // Read request is ignored until STOP
        snap = drive_cnt;
        do_start();
        send_byte(8'h55, 1'b0, "t2_read_nack");
        check("t2_busy_ignore", bus.busy, 1);
        send_byte(8'h12, 1'b0, "t2_data_nack");
        check("t2_busy_still", bus.busy, 1);
        do_stop();
        check("t2_idle", bus.busy, 0);
        check("t2_no_valid", bus.byte_valid, 0);
        check("t2_no_drive", drive_cnt - snap, 0);

        // Address mismatch never drives SDA
        snap = drive_cnt;
        do_start();
        send_byte(8'h56, 1'b0, "t3_mismatch_nack");
        send_byte(8'hFF, 1'b0, "t3_data_nack");
        send_byte(8'h00, 1'b0, "t3_data2_nack");
        do_stop();
        check("t3_no_drive", drive_cnt - snap, 0);

        // Consumer stalled: second byte overruns and is NACKed
        bus.byte_ready = 1'b0;
        do_start();
        send_byte(8'h54, 1'b1, "t4_addr_ack");
        exp_q.push_back({1'b1, 8'h11});
        send_byte(8'h11, 1'b1, "t4_first_ack");
        send_byte(8'h22, 1'b0, "t4_second_nack");
        check("t4_overrun", bus.overrun, 1);
        check("t4_hold_data", bus.byte_data, 8'h11);
        check("t4_hold_valid", bus.byte_valid, 1);
        check("t4_hold_first", bus.byte_first, 1);
        do_stop();
        check("t4_hold_after_stop", bus.byte_data, 8'h11);
        bus.byte_ready = 1'b1;
        wait_clk(3);
        check("t4_drained", bus.byte_valid, 0);

        // Two bytes, repeated START, one more byte
        do_start();
        send_byte(8'h54, 1'b1, "t5_addr_ack");
        exp_q.push_back({1'b1, 8'h33});
        send_byte(8'h33, 1'b1, "t5_b0_ack");
        exp_q.push_back({1'b0, 8'h7E});
        send_byte(8'h7E, 1'b1, "t5_b1_ack");
        do_start();
        send_byte(8'h54, 1'b1, "t5_rs_addr_ack");
        exp_q.push_back({1'b1, 8'h44});
        send_byte(8'h44, 1'b1, "t5_b2_ack");
        do_stop();
        check("t5_overrun_sticky", bus.overrun, 1);

        // Reset in the middle of a data byte
        do_start();
        send_byte(8'h54, 1'b1, "t6_addr_ack");
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        wait_clk(1);
        check("t6_rst_drive", bus.sda_drive_low, 0);
        check("t6_rst_valid", bus.byte_valid, 0);
        check("t6_rst_first", bus.byte_first, 0);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_overrun", bus.overrun, 0);
        check("t6_rst_data", bus.byte_data, 0);
        reset = 1'b0;
        wait_clk(2);
        send_bit(1'b0);
        check("t6_idle_ignores_sck", bus.busy, 0);
        do_start();
        send_byte(8'h54, 1'b1, "t6_post_addr_ack");
        exp_q.push_back({1'b1, 8'h96});
        send_byte(8'h96, 1'b1, "t6_post_data_ack");
        do_stop();

        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            wait_clk(1);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
